// File: rtl/sio_baud_gen_if.sv
// ============================================================================
// Module      : sio_baud_gen_if
// Description : Control/status bundle between the SIO core and its baud generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sio_baud_gen_if #(
    parameter int CNT_W  = 16,
    parameter int FRAC_W = 4
) ();
    logic              en;
    logic              div_wr;
    logic [CNT_W-1:0]  div_in;
    logic [FRAC_W-1:0] frac_in;
    logic              div_pend;
    logic              tick_ovs;
    logic              tick_bit;
    logic              sio_clk;

    modport master (
        output en, div_wr, div_in, frac_in,
        input  div_pend, tick_ovs, tick_bit, sio_clk
    );

    modport slave (
        input  en, div_wr, div_in, frac_in,
        output div_pend, tick_ovs, tick_bit, sio_clk
    );
endinterface

`default_nettype wire

// File: rtl/sio_baud_gen.sv
// ============================================================================
// Module      : sio_baud_gen
// Description : Programmable baud generator; shadowed divisor applied at period
//               boundaries. Optional fractional divisor via SIO_BAUD_FRAC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sio_baud_gen #(
    parameter int CNT_W   = 16,
    parameter int DEF_DIV = 312,
    parameter int OVS     = 16,
    parameter int FRAC_W  = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    sio_baud_gen_if.slave     bus
);

    localparam int                 c_ovs_w    = (OVS > 2) ? $clog2(OVS) : 1;
    localparam logic [c_ovs_w-1:0] c_ovs_last = c_ovs_w'(OVS - 1);
    localparam logic [c_ovs_w-1:0] c_ovs_one  = c_ovs_w'(1);
    localparam logic [CNT_W-1:0]   c_def_div  = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0]   c_min_div  = CNT_W'(2);
    localparam logic [CNT_W-1:0]   c_one      = CNT_W'(1);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   div_act_q, div_act_d;
    logic [CNT_W-1:0]   shadow_q, shadow_d;
    logic               pend_q, pend_d;
    logic [c_ovs_w-1:0] ovs_cnt_q, ovs_cnt_d;
    logic               tick_ovs_q, tick_ovs_d;
    logic               tick_bit_q, tick_bit_d;
    logic               sio_clk_q, sio_clk_d;

    logic [CNT_W-1:0]   w_wr_div;
    logic [CNT_W-1:0]   w_next_div;
    logic [CNT_W-1:0]   w_reload;

    assign w_wr_div   = (bus.div_in < c_min_div) ? c_min_div : bus.div_in;
    // Divisor governing the next period: a coincident write beats the shadow.
    assign w_next_div = bus.div_wr ? w_wr_div : (pend_q ? shadow_q : div_act_q);

`ifdef SIO_BAUD_FRAC_EN
    logic [FRAC_W-1:0]  frac_acc_q, frac_acc_d;
    logic [FRAC_W-1:0]  frac_act_q, frac_act_d;
    logic [FRAC_W-1:0]  frac_sh_q, frac_sh_d;
    logic [FRAC_W-1:0]  w_next_frac;
    logic [FRAC_W-1:0]  w_acc_sum;
    logic               w_carry;

    assign w_next_frac          = bus.div_wr ? bus.frac_in : (pend_q ? frac_sh_q : frac_act_q);
    assign {w_carry, w_acc_sum} = {1'b0, frac_acc_q} + {1'b0, w_next_frac};
    // Accumulator carry stretches the upcoming period by one clock.
    assign w_reload             = w_carry ? w_next_div : (w_next_div - c_one);
`else
    assign w_reload             = w_next_div - c_one;
`endif

    always_comb begin
        cnt_d      = cnt_q;
        div_act_d  = div_act_q;
        shadow_d   = shadow_q;
        pend_d     = pend_q;
        ovs_cnt_d  = ovs_cnt_q;
        tick_ovs_d = 1'b0;
        tick_bit_d = 1'b0;
        sio_clk_d  = sio_clk_q;
`ifdef SIO_BAUD_FRAC_EN
        frac_acc_d = frac_acc_q;
        frac_act_d = frac_act_q;
        frac_sh_d  = frac_sh_q;
`endif
        if (bus.div_wr) begin
            shadow_d = w_wr_div;
            pend_d   = 1'b1;
`ifdef SIO_BAUD_FRAC_EN
            frac_sh_d = bus.frac_in;
`endif
        end

        if (!bus.en) begin
            div_act_d = w_next_div;
            shadow_d  = w_next_div;
            pend_d    = 1'b0;
            cnt_d     = w_next_div - c_one;
            ovs_cnt_d = '0;
            sio_clk_d = 1'b0;
`ifdef SIO_BAUD_FRAC_EN
            frac_act_d = w_next_frac;
            frac_sh_d  = w_next_frac;
            frac_acc_d = '0;
`endif
        end else if (cnt_q == '0) begin
            div_act_d  = w_next_div;
            shadow_d   = w_next_div;
            pend_d     = 1'b0;
            cnt_d      = w_reload;
            tick_ovs_d = 1'b1;
            tick_bit_d = (ovs_cnt_q == c_ovs_last);
            ovs_cnt_d  = ovs_cnt_q + c_ovs_one;
            sio_clk_d  = ~sio_clk_q;
`ifdef SIO_BAUD_FRAC_EN
            frac_act_d = w_next_frac;
            frac_sh_d  = w_next_frac;
            frac_acc_d = w_acc_sum;
`endif
        end else begin
            cnt_d = cnt_q - c_one;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= c_def_div - c_one;
            div_act_q  <= c_def_div;
            shadow_q   <= c_def_div;
            pend_q     <= 1'b0;
            ovs_cnt_q  <= '0;
            tick_ovs_q <= 1'b0;
            tick_bit_q <= 1'b0;
            sio_clk_q  <= 1'b0;
`ifdef SIO_BAUD_FRAC_EN
            frac_acc_q <= '0;
            frac_act_q <= '0;
            frac_sh_q  <= '0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            shadow_q   <= shadow_d;
            pend_q     <= pend_d;
            ovs_cnt_q  <= ovs_cnt_d;
            tick_ovs_q <= tick_ovs_d;
            tick_bit_q <= tick_bit_d;
            sio_clk_q  <= sio_clk_d;
`ifdef SIO_BAUD_FRAC_EN
            frac_acc_q <= frac_acc_d;
            frac_act_q <= frac_act_d;
            frac_sh_q  <= frac_sh_d;
`endif
        end
    end

    assign bus.div_pend = pend_q;
    assign bus.tick_ovs = tick_ovs_q;
    assign bus.tick_bit = tick_bit_q;
    assign bus.sio_clk  = sio_clk_q;

endmodule

`default_nettype wire

// File: tb/tb_sio_baud_gen.sv
// ============================================================================
// Module      : tb_sio_baud_gen
// Description : Directed bench for sio_baud_gen (DEF_DIV=4, OVS=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sio_baud_gen;

    localparam int CNT_W  = 16;
    localparam int FRAC_W = 4;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    sio_baud_gen_if #(.CNT_W(CNT_W), .FRAC_W(FRAC_W)) bus ();

    sio_baud_gen #(
        .CNT_W   (CNT_W),
        .DEF_DIV (4),
        .OVS     (4),
        .FRAC_W  (FRAC_W)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic skip(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Edges until tick_ovs is seen (bounded at 100); also reports any div_pend seen.
    task automatic wait_tick(output int n, output logic pend_seen);
        n = 0;
        pend_seen = 1'b0;
        do begin
            step();
            n++;
            pend_seen |= bus.div_pend;
        end while (!bus.tick_ovs && n < 100);
    endtask

    task automatic test_reset();
        logic exp_t, exp_b, exp_s;
        rst = 1'b1;
        bus.en = 1'b1;
        skip(3);
        n_vec++;
        if ({bus.tick_ovs, bus.tick_bit, bus.sio_clk, bus.div_pend} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_outputs got=%b want=0000",
                     {bus.tick_ovs, bus.tick_bit, bus.sio_clk, bus.div_pend});
        end
        rst = 1'b0;
        // Edge k counted from the first edge with rst low: ticks land on k=4,8,...
        for (int k = 1; k <= 32; k++) begin
            step();
            exp_t = (k % 4 == 0);
            exp_b = (k % 16 == 0);
            exp_s = ((k / 4) % 2) == 1;
            n_vec++;
            if ({bus.tick_ovs, bus.tick_bit, bus.sio_clk} !== {exp_t, exp_b, exp_s}) begin
                n_err++;
                $display("FAIL default_run k=%0d got=%b want=%b", k,
                         {bus.tick_ovs, bus.tick_bit, bus.sio_clk}, {exp_t, exp_b, exp_s});
            end
        end
    endtask

    task automatic test_mid_write();
        int n;
        logic p;
        step();
        bus.div_wr = 1'b1;
        bus.div_in = 16'd6;
        step();
        bus.div_wr = 1'b0;
        n_vec++;
        if (bus.div_pend !== 1'b1) begin
            n_err++;
            $display("FAIL mid_write_pend got=%b want=1", bus.div_pend);
        end
        wait_tick(n, p);
        n_vec++;
        if (n != 2 || bus.div_pend !== 1'b0) begin
            n_err++;
            $display("FAIL mid_write_current got=%0d/%b want=2/0", n, bus.div_pend);
        end
        for (int j = 0; j < 2; j++) begin
            wait_tick(n, p);
            n_vec++;
            if (n != 6) begin
                n_err++;
                $display("FAIL mid_write_period got=%0d want=6", n);
            end
        end
    endtask

    task automatic test_tc_write();
        int n;
        logic p;
        skip(5);
        bus.div_wr = 1'b1;
        bus.div_in = 16'd10;
        step();
        bus.div_wr = 1'b0;
        n_vec++;
        if (bus.tick_ovs !== 1'b1 || bus.div_pend !== 1'b0) begin
            n_err++;
            $display("FAIL tc_write_edge got=%b%b want=10", bus.tick_ovs, bus.div_pend);
        end
        for (int j = 0; j < 2; j++) begin
            wait_tick(n, p);
            n_vec++;
            if (n != 10 || p !== 1'b0) begin
                n_err++;
                $display("FAIL tc_write_period got=%0d/%b want=10/0", n, p);
            end
        end
    endtask

    task automatic test_clamp();
        int n;
        logic p, s;
        bus.div_wr = 1'b1;
        bus.div_in = 16'd0;
        step();
        bus.div_wr = 1'b0;
        wait_tick(n, p);
        n_vec++;
        if (n != 9) begin
            n_err++;
            $display("FAIL clamp0_remainder got=%0d want=9", n);
        end
        s = bus.sio_clk;
        wait_tick(n, p);
        n_vec++;
        if (n != 2 || bus.sio_clk === s) begin
            n_err++;
            $display("FAIL clamp0_period got=%0d/%b want=2/%b", n, bus.sio_clk, ~s);
        end
        bus.div_wr = 1'b1;
        bus.div_in = 16'd1;
        step();
        bus.div_wr = 1'b0;
        wait_tick(n, p);
        n_vec++;
        if (n != 1) begin
            n_err++;
            $display("FAIL clamp1_remainder got=%0d want=1", n);
        end
        for (int j = 0; j < 2; j++) begin
            s = bus.sio_clk;
            wait_tick(n, p);
            n_vec++;
            if (n != 2 || bus.sio_clk === s) begin
                n_err++;
                $display("FAIL clamp1_period got=%0d/%b want=2/%b", n, bus.sio_clk, ~s);
            end
        end
    endtask

    task automatic test_en_low();
        int n;
        logic p;
        bus.div_wr = 1'b1;
        bus.div_in = 16'd5;
        step();
        bus.div_wr = 1'b0;
        wait_tick(n, p);
        skip(2);
        bus.en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 9) begin
                bus.div_wr = 1'b1;
                bus.div_in = 16'd7;
            end
            step();
            bus.div_wr = 1'b0;
            n_vec++;
            if ({bus.tick_ovs, bus.tick_bit, bus.sio_clk, bus.div_pend} !== 4'b0000) begin
                n_err++;
                $display("FAIL en_low i=%0d got=%b want=0000", i,
                         {bus.tick_ovs, bus.tick_bit, bus.sio_clk, bus.div_pend});
            end
        end
        bus.en = 1'b1;
        // ovs_cnt restarts from zero, so the bit tick lands on the 4th tick.
        for (int j = 0; j < 4; j++) begin
            wait_tick(n, p);
            n_vec++;
            if (n != 7 || bus.tick_bit !== (j == 3)) begin
                n_err++;
                $display("FAIL en_resume j=%0d got=%0d/%b want=7/%b", j, n, bus.tick_bit, (j == 3));
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic p;
        bus.div_wr = 1'b1;
        bus.div_in = 16'd3;
        step();
        bus.div_in = 16'd9;
        step();
        bus.div_wr = 1'b0;
        wait_tick(n, p);
        n_vec++;
        if (n != 5) begin
            n_err++;
            $display("FAIL b2b_current got=%0d want=5", n);
        end
        wait_tick(n, p);
        n_vec++;
        if (n != 9) begin
            n_err++;
            $display("FAIL b2b_last_wins got=%0d want=9", n);
        end
    endtask

`ifdef SIO_BAUD_FRAC_EN
    task automatic test_frac();
        int n, total;
        logic p;
        bus.div_wr  = 1'b1;
        bus.div_in  = 16'd4;
        bus.frac_in = 4'd8;
        step();
        bus.div_wr  = 1'b0;
        bus.frac_in = 4'd0;
        wait_tick(n, p);
        total = 0;
        for (int j = 0; j < 32; j++) begin
            wait_tick(n, p);
            total += n;
            if (j == 0) begin
                n_vec++;
                if (n != 4) begin
                    n_err++;
                    $display("FAIL frac_first got=%0d want=4", n);
                end
            end
        end
        n_vec++;
        if (total != 144) begin
            n_err++;
            $display("FAIL frac_span got=%0d want=144", total);
        end
    endtask
`endif

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b1;
        bus.en      = 1'b0;
        bus.div_wr  = 1'b0;
        bus.div_in  = '0;
        bus.frac_in = '0;
        test_reset();
        test_mid_write();
        test_tc_write();
        test_clamp();
        test_en_low();
        test_back_to_back();
`ifdef SIO_BAUD_FRAC_EN
        test_frac();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
